// File: rtl/digit_scan_mux.sv
// digit_scan_mux
//   Time-multiplexes NUM_DIGITS data words onto one shared data bus. Each
//   digit is driven for ON_TICKS scan ticks. Between digits, the block can
//   insert a gap of BLANK_TICKS ticks with every digit off. A scan tick comes
//   from an internal prescaler, once every TICK_DIV fast_clk cycles. Every
//   output comes from a flop.
//
//   Optional feature macro: DIGIT_BLINK_EN
//     Adds the blink_mask port and the BLINK_FRAMES parameter. Every
//     BLINK_FRAMES frames, a blink phase toggles. While the phase is set,
//     digits selected by blink_mask are kept dark.
//
// Ports
//   fast_clk    in   system clock
//   rst         in   asynchronous active-low reset
//   en          in   scan enable (0 freezes timing and darkens all digits)
//   data_in     in   digit k occupies bits [k*DATA_W +: DATA_W]
//   digit_mask  in   bit k=1 keeps digit k dark during its slot
//   blink_mask  in   (DIGIT_BLINK_EN only) digits that blink
//   sel         out  one-hot digit enable, polarity per SEL_ACTIVE_LOW
//   data_out    out  data word of the digit being driven
//   digit_idx   out  index of the current digit (or the last one, while blanking)
//   frame_done  out  one-cycle pulse when the last digit's on-time ends
module digit_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int DATA_W         = 4,
    parameter int TICK_DIV       = 50000,
    parameter int ON_TICKS       = 4,
    parameter int BLANK_TICKS    = 1,
    parameter int SEL_ACTIVE_LOW = 1
`ifdef DIGIT_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 64
`endif
) (
    input  logic                                                   fast_clk,
    input  logic                                                   rst,
    input  logic                                                   en,
    input  logic [NUM_DIGITS*DATA_W-1:0]                           data_in,
    input  logic [NUM_DIGITS-1:0]                                  digit_mask,
`ifdef DIGIT_BLINK_EN
    input  logic [NUM_DIGITS-1:0]                                  blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]                                  sel,
    output logic [DATA_W-1:0]                                      data_out,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                                   frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE   = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SCAN  = 1'b1;

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick;
    logic                  advance;
    logic [NUM_DIGITS-1:0] suppress;
    logic [NUM_DIGITS-1:0] sel_hot;

    assign tick = en && (presc_q == PRESC_LAST);

`ifdef DIGIT_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_done_d) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign suppress = digit_mask | (blink_mask & {NUM_DIGITS{blink_phase_q}});
`else
    assign suppress = digit_mask;
`endif

    always_comb begin
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        advance      = 1'b0;

        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (tick) begin
            if (state_q == ST_SCAN) begin
                if (cnt_q == ON_LAST) begin
                    cnt_d        = '0;
                    frame_done_d = (idx_q == LAST_IDX);
                    if (BLANK_TICKS > 0) begin
                        state_d = ST_BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (BLANK_TICKS == 0 || cnt_q == BLANK_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Explicit wrap so non-power-of-two digit counts never reach an unused index.
        // The data word is captured only here, so it stays stable for the whole slot.
        if (advance) begin
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            state_d = ST_SCAN;
            data_d  = data_in[idx_d*DATA_W +: DATA_W];
        end

        // sel is derived from the next state so it switches on the same edge as the FSM.
        sel_hot = SEL_ONE << idx_d;
        if (en && state_d == ST_SCAN && !suppress[idx_d]) begin
            sel_d = (SEL_ACTIVE_LOW != 0) ? ~sel_hot : sel_hot;
        end else begin
            sel_d = SEL_IDLE;
        end
    end

    always_ff @(posedge fast_clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            state_q      <= ST_BLANK;
            idx_q        <= LAST_IDX;
            data_q       <= '0;
            sel_q        <= SEL_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign data_out   = data_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule
